// File: rtl/emmc_clkgen_if.sv
// emmc_clkgen_if: control/status bundle between the host state machine and the eMMC clock generator.
interface emmc_clkgen_if #(parameter int DIV_W = 8);
    logic             en_i;
    logic [DIV_W-1:0] div_i;
    logic             div_ld_i;
    logic             div_ack_o;
    logic             clk_pad_o;
    logic             rise_stb_o;
    logic             fall_stb_o;
    logic             running_o;
    logic [DIV_W-1:0] div_o;
    modport master (
        output en_i, div_i, div_ld_i,
        input  div_ack_o, clk_pad_o, rise_stb_o, fall_stb_o, running_o, div_o
    );
    modport slave (
        input  en_i, div_i, div_ld_i,
        output div_ack_o, clk_pad_o, rise_stb_o, fall_stb_o, running_o, div_o
    );
endinterface

// File: rtl/emmc_clkgen.sv
// emmc_clkgen: programmable glitch-free eMMC pad clock with rise/fall strobes,
// divisor changes only at period boundaries and park-low stop.
module emmc_clkgen #(
    parameter int DIV_W    = 8,
    parameter int INIT_DIV = 31
) (
    input logic          clk_i,
    input logic          nrst_i,
    emmc_clkgen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
    state_t           r_state, w_state_nx;
    logic [DIV_W-1:0] r_cnt, w_cnt_nx, r_div, r_pend_div;
    logic             r_pad, r_rise, r_fall, r_ack, r_run, r_pend_v;
    logic             w_pad_nx, w_rise_nx, w_fall_nx, w_end, w_upd;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_pad_nx   = r_pad;
        w_rise_nx  = 1'b0;
        w_fall_nx  = 1'b0;
        w_end      = r_cnt == r_div;
        case (r_state)
            IDLE: begin
                w_cnt_nx   = '0;
                w_pad_nx   = 1'b0;
                w_state_nx = bus.en_i ? LOW : IDLE;
            end
            LOW: if (w_end) begin
                w_cnt_nx   = '0;
                w_state_nx = bus.en_i ? HIGH : IDLE;
                w_pad_nx   = bus.en_i;
                w_rise_nx  = bus.en_i;
            end
            HIGH: if (w_end) begin
                w_cnt_nx   = '0;
                w_state_nx = bus.en_i ? LOW : IDLE;
                w_pad_nx   = 1'b0;
                w_fall_nx  = 1'b1;
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = IDLE;
                w_pad_nx   = 1'b0;
            end
        endcase
        // a new divisor may only take effect between periods or while stopped
        w_upd = (r_state == IDLE || (r_state == HIGH && w_end)) && (bus.div_ld_i || r_pend_v);
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pad   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_pad   <= w_pad_nx;
            r_rise  <= w_rise_nx;
            r_fall  <= w_fall_nx;
            r_run   <= w_state_nx != IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_div      <= DIV_W'(INIT_DIV);
            r_pend_div <= '0;
            r_pend_v   <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_ack <= w_upd;
            if (w_upd) begin
                r_div    <= bus.div_ld_i ? bus.div_i : r_pend_div;
                r_pend_v <= 1'b0;
            end else if (bus.div_ld_i) begin
                r_pend_div <= bus.div_i;
                r_pend_v   <= 1'b1;
            end
        end
    end

    assign bus.clk_pad_o  = r_pad;
    assign bus.rise_stb_o = r_rise;
    assign bus.fall_stb_o = r_fall;
    assign bus.div_ack_o  = r_ack;
    assign bus.running_o  = r_run;
    assign bus.div_o      = r_div;
endmodule

// File: tb/tb_emmc_clkgen.sv
// tb_emmc_clkgen: scoreboard bench; tests queue expected strobe/ack cycles, a monitor pops and compares them.
module tb_emmc_clkgen;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_rise[$];
    int   exp_fall[$];
    int   exp_ack[$];

    emmc_clkgen_if #(.DIV_W(8)) bus ();
    emmc_clkgen #(.DIV_W(8), .INIT_DIV(3)) dut (.clk_i(clk), .nrst_i(nrst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        bus.en_i = 1'b0;
        bus.div_ld_i = 1'b0;
        bus.div_i = '0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.clk_pad_o !== 1'b0 || bus.running_o !== 1'b0 || bus.rise_stb_o !== 1'b0 ||
            bus.fall_stb_o !== 1'b0 || bus.div_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs pad=%b run=%b rise=%b fall=%b ack=%b expected all 0",
                     bus.clk_pad_o, bus.running_o, bus.rise_stb_o, bus.fall_stb_o, bus.div_ack_o);
        end
        checks++;
        if (bus.div_o !== 8'd3) begin
            errors++;
            $display("FAIL reset_div got=%0d expected=3", bus.div_o);
        end
    endtask

    task automatic test_basic();
        int c0;
        do_reset();
        c0 = cyc;
        bus.en_i = 1'b1;
        exp_rise.push_back(c0 + 5); exp_rise.push_back(c0 + 13); exp_rise.push_back(c0 + 21);
        exp_fall.push_back(c0 + 9); exp_fall.push_back(c0 + 17);
        wait_until(c0 + 1);
        checks++;
        if (bus.running_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_running got=%b expected=1", bus.running_o);
        end
        wait_until(c0 + 22);
        checks++;
        if (exp_rise.size() + exp_fall.size() != 0) begin
            errors++;
            $display("FAIL basic_missing got=%0d pending expected=0", exp_rise.size() + exp_fall.size());
        end
    endtask

    task automatic test_div0();
        int c0;
        do_reset();
        c0 = cyc;
        bus.en_i = 1'b1;
        exp_rise.push_back(c0 + 5);
        for (int k = 0; k <= 10; k += 2) exp_rise.push_back(c0 + 10 + k);
        exp_fall.push_back(c0 + 9);
        for (int k = 0; k <= 8; k += 2) exp_fall.push_back(c0 + 11 + k);
        exp_ack.push_back(c0 + 9);
        wait_until(c0 + 6);
        bus.div_i = 8'd0;
        bus.div_ld_i = 1'b1;
        @(negedge clk);
        bus.div_ld_i = 1'b0;
        wait_until(c0 + 20);
        checks++;
        if (bus.div_o !== 8'd0) begin
            errors++;
            $display("FAIL div0_value got=%0d expected=0", bus.div_o);
        end
        checks++;
        if (exp_rise.size() + exp_fall.size() + exp_ack.size() != 0) begin
            errors++;
            $display("FAIL div0_missing got=%0d pending expected=0",
                     exp_rise.size() + exp_fall.size() + exp_ack.size());
        end
    endtask

    task automatic test_mid_high_load();
        int c0;
        do_reset();
        c0 = cyc;
        bus.en_i = 1'b1;
        exp_rise.push_back(c0 + 5); exp_rise.push_back(c0 + 11);
        exp_rise.push_back(c0 + 15); exp_rise.push_back(c0 + 19);
        exp_fall.push_back(c0 + 9); exp_fall.push_back(c0 + 13); exp_fall.push_back(c0 + 17);
        exp_ack.push_back(c0 + 9);
        wait_until(c0 + 6);
        bus.div_i = 8'd1;
        bus.div_ld_i = 1'b1;
        @(negedge clk);
        bus.div_ld_i = 1'b0;
        wait_until(c0 + 8);
        checks++;
        if (bus.div_o !== 8'd3) begin
            errors++;
            $display("FAIL midload_before got=%0d expected=3", bus.div_o);
        end
        wait_until(c0 + 9);
        checks++;
        if (bus.div_o !== 8'd1) begin
            errors++;
            $display("FAIL midload_after got=%0d expected=1", bus.div_o);
        end
        wait_until(c0 + 20);
        checks++;
        if (exp_rise.size() + exp_fall.size() + exp_ack.size() != 0) begin
            errors++;
            $display("FAIL midload_missing got=%0d pending expected=0",
                     exp_rise.size() + exp_fall.size() + exp_ack.size());
        end
    endtask

    task automatic test_stop();
        int c0, c1;
        do_reset();
        c0 = cyc;
        bus.en_i = 1'b1;
        exp_rise.push_back(c0 + 5);
        exp_fall.push_back(c0 + 9);
        wait_until(c0 + 6);
        bus.en_i = 1'b0;
        wait_until(c0 + 8);
        checks++;
        if (bus.clk_pad_o !== 1'b1 || bus.running_o !== 1'b1) begin
            errors++;
            $display("FAIL stop_high_kept pad=%b run=%b expected 1 1", bus.clk_pad_o, bus.running_o);
        end
        wait_until(c0 + 9);
        checks++;
        if (bus.running_o !== 1'b0 || bus.clk_pad_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_parked run=%b pad=%b expected 0 0", bus.running_o, bus.clk_pad_o);
        end
        wait_until(c0 + 14);
        c1 = cyc;
        bus.en_i = 1'b1;
        exp_rise.push_back(c1 + 5);
        exp_fall.push_back(c1 + 9);
        wait_until(c1 + 10);
        checks++;
        if (exp_rise.size() + exp_fall.size() != 0) begin
            errors++;
            $display("FAIL stop_missing got=%0d pending expected=0", exp_rise.size() + exp_fall.size());
        end
    endtask

    task automatic test_back_to_back_loads();
        int c0, c2;
        do_reset();
        c0 = cyc;
        bus.en_i = 1'b1;
        exp_rise.push_back(c0 + 5); exp_rise.push_back(c0 + 19);
        exp_fall.push_back(c0 + 9); exp_fall.push_back(c0 + 29);
        exp_ack.push_back(c0 + 9);
        wait_until(c0 + 5);
        bus.div_i = 8'd5;
        bus.div_ld_i = 1'b1;
        @(negedge clk);
        bus.div_i = 8'd9;
        @(negedge clk);
        bus.div_ld_i = 1'b0;
        wait_until(c0 + 8);
        checks++;
        if (bus.div_o !== 8'd3) begin
            errors++;
            $display("FAIL b2b_before got=%0d expected=3", bus.div_o);
        end
        wait_until(c0 + 22);
        checks++;
        if (bus.div_o !== 8'd9) begin
            errors++;
            $display("FAIL b2b_last_wins got=%0d expected=9", bus.div_o);
        end
        bus.en_i = 1'b0;
        wait_until(c0 + 32);
        c2 = cyc;
        bus.div_i = 8'd2;
        bus.div_ld_i = 1'b1;
        exp_ack.push_back(c2 + 1);
        exp_ack.push_back(c2 + 4);
        @(negedge clk);
        bus.div_ld_i = 1'b0;
        checks++;
        if (bus.div_o !== 8'd2) begin
            errors++;
            $display("FAIL idle_load got=%0d expected=2", bus.div_o);
        end
        wait_until(c2 + 3);
        bus.div_ld_i = 1'b1;
        @(negedge clk);
        bus.div_ld_i = 1'b0;
        wait_until(c2 + 6);
        checks++;
        if (exp_rise.size() + exp_fall.size() + exp_ack.size() != 0) begin
            errors++;
            $display("FAIL b2b_missing got=%0d pending expected=0",
                     exp_rise.size() + exp_fall.size() + exp_ack.size());
        end
    endtask

    task automatic test_async_reset();
        int c0;
        do_reset();
        c0 = cyc;
        bus.en_i = 1'b1;
        bus.div_i = 8'd1;
        bus.div_ld_i = 1'b1;
        exp_ack.push_back(c0 + 1);
        exp_rise.push_back(c0 + 3);
        @(negedge clk);
        bus.div_ld_i = 1'b0;
        wait_until(c0 + 3);
        checks++;
        if (bus.clk_pad_o !== 1'b1 || bus.div_o !== 8'd1) begin
            errors++;
            $display("FAIL areset_pre pad=%b div=%0d expected 1 1", bus.clk_pad_o, bus.div_o);
        end
        nrst = 1'b0;
        #1;
        checks++;
        if (bus.clk_pad_o !== 1'b0 || bus.running_o !== 1'b0 || bus.div_o !== 8'd3) begin
            errors++;
            $display("FAIL areset_now pad=%b run=%b div=%0d expected 0 0 3",
                     bus.clk_pad_o, bus.running_o, bus.div_o);
        end
        repeat (3) @(negedge clk);
        bus.en_i = 1'b0;
        nrst = 1'b1;
        @(negedge clk);
        checks++;
        if (exp_rise.size() + exp_ack.size() != 0) begin
            errors++;
            $display("FAIL areset_missing got=%0d pending expected=0", exp_rise.size() + exp_ack.size());
        end
    endtask

    initial begin
        bus.en_i = 1'b0;
        bus.div_ld_i = 1'b0;
        bus.div_i = '0;
        fork
            forever begin
                int e;
                @(posedge clk);
                #1;
                checks++;
                if ((bus.rise_stb_o && bus.fall_stb_o) || (bus.rise_stb_o && !bus.clk_pad_o) ||
                    (bus.fall_stb_o && bus.clk_pad_o)) begin
                    errors++;
                    $display("FAIL strobe_consistency cyc=%0d rise=%b fall=%b pad=%b",
                             cyc, bus.rise_stb_o, bus.fall_stb_o, bus.clk_pad_o);
                end
                if (bus.rise_stb_o) begin
                    checks++;
                    e = exp_rise.size() != 0 ? exp_rise.pop_front() : -1;
                    if (e != cyc) begin
                        errors++;
                        $display("FAIL rise_time got=%0d expected=%0d", cyc, e);
                    end
                end
                if (bus.fall_stb_o) begin
                    checks++;
                    e = exp_fall.size() != 0 ? exp_fall.pop_front() : -1;
                    if (e != cyc) begin
                        errors++;
                        $display("FAIL fall_time got=%0d expected=%0d", cyc, e);
                    end
                end
                if (bus.div_ack_o) begin
                    checks++;
                    e = exp_ack.size() != 0 ? exp_ack.pop_front() : -1;
                    if (e != cyc) begin
                        errors++;
                        $display("FAIL ack_time got=%0d expected=%0d", cyc, e);
                    end
                end
            end
        join_none
        test_reset();
        test_basic();
        test_div0();
        test_mid_high_load();
        test_stop();
        test_back_to_back_loads();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
